duck_hit_ctl: RTL and testbench

//  Shot/hit judge directly downstream of the duck motion controller. Consumes duck xpos/ypos
//  and the mouse cursor + left button, detects each new shot, tests it against the duck's

---
 rtl/duck_hit_ctl.sv | 145 ++++++++++++++
 tb/tb_duck_hit_ctl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/duck_hit_ctl.sv
// duck_hit_ctl: judges each new mouse click against the duck bounding box and
// tracks shots-per-duck, saturating score and the cooldown/hold timers.
module duck_hit_ctl #(
  parameter int DUCK_WIDTH      = 96,
  parameter int DUCK_HEIGHT     = 32,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int SCORE_W         = 10,
  parameter int COOLDOWN_CYCLES = 650000,
  parameter int HOLD_CYCLES     = 6500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_enable,
  input  logic [11:0]        mouse_xpos,
  input  logic [11:0]        mouse_ypos,
  input  logic               mouse_left,
  input  logic [11:0]        duck_xpos,
  input  logic [11:0]        duck_ypos,
  output logic               shot_fired,
  output logic               target_killed,
  output logic               duck_escaped,
  output logic [1:0]         shots_left,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [2:0] {IDLE, ARMED, EVAL, COOLDOWN, KILLED, ESCAPED} state_t;

  localparam int TIMER_MAX = (COOLDOWN_CYCLES > HOLD_CYCLES) ? COOLDOWN_CYCLES : HOLD_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);

  localparam logic [TW-1:0] COOL_LOAD  = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
  localparam logic [1:0]    SHOTS_INIT = 2'(SHOTS_PER_DUCK);
  localparam logic [12:0]   W13        = 13'(DUCK_WIDTH);
  localparam logic [12:0]   H13        = 13'(DUCK_HEIGHT);

  state_t state, state_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic               btn_q;
  logic               click_rise;
  logic [11:0]        mx_q, my_q, dx_q, dy_q;
  logic               hit;
  logic               shot_nxt, kill_nxt, esc_nxt;
  logic [1:0]         shots_nxt;
  logic [SCORE_W-1:0] score_nxt;

  assign click_rise = mouse_left & ~btn_q;

  // 13-bit compare so duck x + width cannot wrap past the 12-bit screen range.
  assign hit = ({1'b0, mx_q} >= {1'b0, dx_q}) && ({1'b0, mx_q} < ({1'b0, dx_q} + W13)) &&
               ({1'b0, my_q} >= {1'b0, dy_q}) && ({1'b0, my_q} < ({1'b0, dy_q} + H13));

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      btn_q         <= 1'b0;
      shot_fired    <= 1'b0;
      target_killed <= 1'b0;
      duck_escaped  <= 1'b0;
      shots_left    <= SHOTS_INIT;
      score         <= '0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      btn_q         <= mouse_left;
      shot_fired    <= shot_nxt;
      target_killed <= kill_nxt;
      duck_escaped  <= esc_nxt;
      shots_left    <= shots_nxt;
      score         <= score_nxt;
    end
  end

  // NOTE: snapshot registers carry no reset; EVAL is only ever entered right after a capture.
  always_ff @(posedge clk) begin
    if (state == ARMED && click_rise) begin
      mx_q <= mouse_xpos;
      my_q <= mouse_ypos;
      dx_q <= duck_xpos;
      dy_q <= duck_ypos;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    if (!game_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = ARMED;
        ARMED:    if (click_rise) state_nxt = EVAL;
        EVAL: begin
          if (hit)                  state_nxt = KILLED;
          else if (shots_left > 2'd1) state_nxt = COOLDOWN;
          else                      state_nxt = ESCAPED;
        end
        COOLDOWN, KILLED, ESCAPED: if (timer == '0) state_nxt = ARMED;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Disabling the game freezes score/shots and suppresses any pending EVAL result.
  always_comb begin
    shot_nxt  = 1'b0;
    kill_nxt  = 1'b0;
    esc_nxt   = 1'b0;
    shots_nxt = shots_left;
    score_nxt = score;
    timer_nxt = timer;
    if (game_enable) begin
      case (state)
        IDLE: begin
          score_nxt = '0;
          shots_nxt = SHOTS_INIT;
          timer_nxt = '0;
        end
        EVAL: begin
          shot_nxt  = 1'b1;
          shots_nxt = shots_left - 2'd1;
          if (hit) begin
            kill_nxt  = 1'b1;
            timer_nxt = HOLD_LOAD;
            if (score != '1) score_nxt = score + 1'b1;
          end else if (shots_left > 2'd1) begin
            timer_nxt = COOL_LOAD;
          end else begin
            esc_nxt   = 1'b1;
            timer_nxt = HOLD_LOAD;
          end
        end
        COOLDOWN: if (timer != '0) timer_nxt = timer - 1'b1;
        KILLED, ESCAPED: begin
          if (timer == '0) shots_nxt = SHOTS_INIT;
          else             timer_nxt = timer - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_duck_hit_ctl.sv
// Directed bench for duck_hit_ctl: clicks push expected pulse events to a
// scoreboard, a negedge monitor pops and compares them when pulses appear.
module tb_duck_hit_ctl;

  localparam int DX = 100;
  localparam int DY = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_enable;
  logic [11:0] mouse_xpos, mouse_ypos, duck_xpos, duck_ypos;
  logic        mouse_left;
  logic        shot_fired, target_killed, duck_escaped;
  logic [1:0]  shots_left;
  logic [3:0]  score;

  typedef struct {
    int cyc;
    bit kill;
    bit esc;
    int shots;
    int score;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_shots = 3;
  int   m_score = 0;

  duck_hit_ctl #(
    .DUCK_WIDTH(96), .DUCK_HEIGHT(32), .SHOTS_PER_DUCK(3), .SCORE_W(4),
    .COOLDOWN_CYCLES(4), .HOLD_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .game_enable(game_enable),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_left(mouse_left),
    .duck_xpos(duck_xpos), .duck_ypos(duck_ypos),
    .shot_fired(shot_fired), .target_killed(target_killed), .duck_escaped(duck_escaped),
    .shots_left(shots_left), .score(score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a button press; when a shot is expected, model its outcome and queue it.
  task automatic press(input int mx, input int my, input bit expect_shot);
    exp_t e;
    bit   hit;
    mouse_xpos = 12'(mx);
    mouse_ypos = 12'(my);
    mouse_left = 1'b1;
    if (expect_shot) begin
      hit     = (mx >= DX) && (mx < DX + 96) && (my >= DY) && (my < DY + 32);
      e.cyc   = cyc + 2;
      e.kill  = hit;
      e.esc   = !hit && (m_shots == 1);
      m_shots = m_shots - 1;
      if (hit && m_score != 15) m_score = m_score + 1;
      e.shots = m_shots;
      e.score = m_score;
      sb.push_back(e);
    end
  endtask

  task automatic click(input int mx, input int my, input bit expect_shot);
    press(mx, my, expect_shot);
    step(1);
    mouse_left = 1'b0;
  endtask

  // Any pulse must match the head of the scoreboard, in the exact expected cycle.
  always @(negedge clk) begin
    if (shot_fired || target_killed || duck_escaped) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, shot_fired, target_killed, duck_escaped}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("shot_fired", shot_fired, 1);
        check("target_killed", target_killed, mon_e.kill);
        check("duck_escaped", duck_escaped, mon_e.esc);
        check("shots_at_pulse", shots_left, mon_e.shots);
        check("score_at_pulse", score, mon_e.score);
      end
    end
  end

  initial begin
    rst = 1'b1; game_enable = 1'b0; mouse_left = 1'b0;
    mouse_xpos = '0; mouse_ypos = '0;
    duck_xpos = 12'(DX); duck_ypos = 12'(DY);
    step(3);
    check("rst_shots", shots_left, 3);
    check("rst_score", score, 0);
    check("rst_shot_fired", shot_fired, 0);
    check("rst_killed", target_killed, 0);
    check("rst_escaped", duck_escaped, 0);
    rst = 1'b0;
    game_enable = 1'b1;
    step(2);

    // 1: centre hit, hold lasts 8 cycles, then shots reload
    click(150, 210, 1'b1);
    step(8);
    check("t1_hold_shots", shots_left, 2);
    step(1);
    m_shots = 3;
    check("t1_rearm_shots", shots_left, 3);
    check("t1_score", score, 1);
    check("t1_drained", sb.size(), 0);

    // 2: bounding-box edges; the fourth shot is the last and escapes
    click(100, 200, 1'b1); step(9); m_shots = 3;
    click(196, 210, 1'b1); step(5);
    click(150, 232, 1'b1); step(5);
    click(99, 210, 1'b1);  step(9); m_shots = 3;
    check("t2_score", score, 2);
    check("t2_rearm_shots", shots_left, 3);

    // 3: three misses with clicks inside each cooldown
    for (int k = 0; k < 2; k++) begin
      click(0, 0, 1'b1);
      step(1); click(150, 210, 1'b0);
      step(1); click(150, 210, 1'b0);
      step(1);
      check("t3_cool_shots", shots_left, m_shots);
    end
    click(0, 0, 1'b1);
    step(1);
    check("t3_escape_shots", shots_left, 0);
    step(8);
    m_shots = 3;
    check("t3_reload_shots", shots_left, 3);

    // 4: held button gives one shot; click as enable falls gives nothing
    press(150, 210, 1'b1);
    step(100);
    mouse_left = 1'b0;
    step(1);
    m_shots = 3;
    check("t4_held_shots", shots_left, 3);
    check("t4_held_score", score, m_score);
    press(150, 210, 1'b0);
    game_enable = 1'b0;
    step(1);
    mouse_left = 1'b0;
    step(5);
    click(150, 210, 1'b0);
    step(3);
    check("t4_idle_shots", shots_left, 3);
    check("t4_idle_score", score, m_score);

    // 5: re-enable clears score; 16 hits saturate at 15
    game_enable = 1'b1;
    step(1);
    m_score = 0;
    check("t5_start_score", score, 0);
    check("t5_start_shots", shots_left, 3);
    for (int k = 0; k < 16; k++) begin
      click(150, 210, 1'b1);
      step(9);
      m_shots = 3;
    end
    check("t5_saturated", score, 15);
    game_enable = 1'b0;
    step(2);
    check("t5_score_kept", score, 15);
    game_enable = 1'b1;
    step(1);
    m_score = 0;
    check("t5_reenable_score", score, 0);
    check("t5_reenable_shots", shots_left, 3);

    // enable dropped while in EVAL discards the shot
    click(150, 210, 1'b0);
    game_enable = 1'b0;
    step(4);
    check("evaldrop_shots", shots_left, 3);
    game_enable = 1'b1;
    step(1);

    // 6: rst during EVAL and during KILLED
    click(150, 210, 1'b1); step(9); m_shots = 3;
    check("t6_pre_score", score, 1);
    click(150, 210, 1'b0);
    rst = 1'b1;
    step(1);
    check("t6_eval_rst_shots", shots_left, 3);
    check("t6_eval_rst_score", score, 0);
    check("t6_eval_rst_shot", shot_fired, 0);
    rst = 1'b0;
    step(1);
    m_score = 0;
    click(150, 210, 1'b1);
    step(3);
    rst = 1'b1;
    step(1);
    check("t6_kill_rst_shots", shots_left, 3);
    check("t6_kill_rst_score", score, 0);
    check("t6_kill_rst_killed", target_killed, 0);
    rst = 1'b0;
    step(5);

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
